muldiv_seq_unit: RTL and testbench
==================================

Name: muldiv_seq_unit

Overview:
- Parametrised successor to the combinational ALU-control decode.
- Decodes an RV32M funct3 and executes multiply, divide or remainder iteratively over XLEN cycles under a start/busy/done handshake.
- Sits beside the ALU in the execute stage. The core drives start for OP instructions with funct7 = 0000001 and holds the pipeline/PC while busy is high.

Parameters:
- XLEN, 32, operand/result width; legal values are even and ≥ 4.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  request; sampled on rising edge.
- funct3  in  3  operation select, captured with start.
- rs1  in  XLEN  operand A, captured with start.
- rs2  in  XLEN  operand B, captured with start.
- busy  out  1  high while iterating; start is ignored when high.
- done  out  1  one-cycle pulse: result valid.
- result  out  XLEN  registered result; held until the next accepted start completes.

Behaviour:
- Reset (async, rst=0): state=IDLE, busy=0, done=0, result=0, counter=0. Asserting reset mid-operation aborts; no done pulse follows.
- States:
  - IDLE: waiting for a request.
  - CALC: iterating; busy=1.
  - DONE: done=1 for exactly one cycle.
- Accept rule: start is accepted on an edge when state≠CALC (IDLE or DONE). Accepting in DONE gives back-to-back issue. start while in CALC is ignored with no side effects.
- funct3 decode:
  - 000 MUL: low XLEN bits.
  - 001 MULH: signed×signed, high XLEN bits.
  - 010 MULHSU: signed rs1 × unsigned rs2, high.
  - 011 MULHU: unsigned×unsigned, high.
  - 100 DIV: signed quotient.
  - 101 DIVU: unsigned quotient.
  - 110 REM: signed remainder.
  - 111 REMU: unsigned remainder.
- Signed handling:
  - Operands are converted to magnitudes on accept.
  - The result sign is applied in the DONE transition.
  - Product sign = sA xor sB.
  - Quotient sign = sA xor sB; remainder sign = sA (dividend).
- Multiply: radix-2 shift-add into a 2·XLEN accumulator, one bit per CALC cycle. Negation is applied to the full 2·XLEN product before the high/low slice is taken.
- Divide: restoring, one quotient bit per CALC cycle, using an XLEN+1-bit partial remainder.
- Normal latency:
  - Accept edge E0 → CALC, counter=0.
  - Edges E1..E_XLEN perform the iterations.
  - At E_XLEN the state goes to DONE and result is written.
  - done is high in the cycle after E_XLEN, i.e. XLEN+1 cycles after the start edge; busy is high for exactly XLEN cycles.
- Fast paths (no CALC; E0 → DONE directly, latency 1):
  - Divide by zero, rs2=0:
    - DIV/DIVU → all ones.
    - REM/REMU → rs1.
  - Signed overflow, DIV/REM with rs1=100…0 and rs2=all ones:
    - DIV → 100…0.
    - REM → 0.
- Multiply by zero takes the normal path; there is no early termination.
- DONE → IDLE on the next edge unless a new start is accepted (then → CALC or fast path).
- result changes only on entry to DONE. done and busy are never both 1.
- Width rules:
  - Counter width is clog2(XLEN)+1.
  - All arithmetic is modulo the stated widths.
  - X on funct3 while start=0 is don't-care.

Test Plan:
- Reset: rst=0 mid-CALC (after 10 iterations of MUL 7×6) → busy=0, done=0, result=0 immediately. After release, no done pulse until a new start.
- MUL rs1=7, rs2=-6 (0xFFFFFFFA) → busy for 32 cycles, done on cycle 33, result=0xFFFFFFD6. MULH of same → 0xFFFFFFFF. MULHU → 0x00000006.
- MULHSU rs1=0xFFFFFFFF (-1), rs2=0xFFFFFFFF → result=0xFFFFFFFF. MULH 0x80000000×0x80000000 → 0x40000000.
- DIV rs1=-7, rs2=2 → 0xFFFFFFFD (-3). REM → 0xFFFFFFFF (-1). DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC. REMU → 1.
- Corner fast paths, each done on cycle 1 with busy never high:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Handshake: start held high during CALC with different operands → ignored. New start in the DONE cycle → accepted, next done exactly 33 cycles later, first result held until then.

Source files
------------

// File: rtl/muldiv_seq_unit.sv
// Iterative RV32M multiply/divide unit: decodes funct3, runs radix-2 shift-add or
// restoring division over XLEN cycles behind a start/busy/done handshake.
module muldiv_seq_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [1:0]      dbg_state
);
   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   mag_b_q, mag_b_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   rem_q, rem_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   result_q, result_d;

   // Operand capture: sign detection, magnitudes and fast-path results.
   logic            accept, last_iter;
   logic            sgn_a, sgn_b, div0, ovf, fast;
   logic [XLEN-1:0] mag_a_in, mag_b_in, fast_result;

   always_comb begin
      accept    = start && (state_q != S_CALC);
      last_iter = (state_q == S_CALC) && (cnt_q == CW'(XLEN - 1));
      sgn_a     = rs1[XLEN-1] && (funct3 == 3'b001 || funct3 == 3'b010 ||
                                  funct3 == 3'b100 || funct3 == 3'b110);
      sgn_b     = rs2[XLEN-1] && (funct3 == 3'b001 || funct3 == 3'b100 ||
                                  funct3 == 3'b110);
      mag_a_in  = sgn_a ? -rs1 : rs1;
      mag_b_in  = sgn_b ? -rs2 : rs2;
      div0      = funct3[2] && (rs2 == '0);
      ovf       = (funct3 == 3'b100 || funct3 == 3'b110) &&
                  (rs1 == MIN_NEG) && (rs2 == '1);
      fast      = div0 || ovf;
      if (div0) begin
         fast_result = funct3[1] ? rs1 : '1;
      end else begin
         fast_result = funct3[1] ? '0 : MIN_NEG;
      end
   end

   // One iteration step; the multiplier sits in the low half of acc and shifts out,
   // the dividend shifts out of the low half while quotient bits shift in.
   logic [XLEN:0]     mul_sum, div_trial, div_diff;
   logic              q_bit;
   logic [2*XLEN-1:0] acc_step, prod_signed;
   logic [XLEN-1:0]   rem_step, quo_signed, rem_signed, final_result;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
      div_trial = {rem_q, acc_q[XLEN-1]};
      div_diff  = div_trial - {1'b0, mag_b_q};
      q_bit     = ~div_diff[XLEN];
      if (op_q[2]) begin
         acc_step = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], q_bit};
         rem_step = q_bit ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
      end else begin
         acc_step = {mul_sum, acc_q[XLEN-1:1]};
         rem_step = rem_q;
      end
      prod_signed = neg_q ? -acc_step : acc_step;
      quo_signed  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
      rem_signed  = neg_q ? -rem_step : rem_step;
      case (op_q)
         3'b000:                 final_result = prod_signed[XLEN-1:0];
         3'b001, 3'b010, 3'b011: final_result = prod_signed[2*XLEN-1:XLEN];
         3'b100, 3'b101:         final_result = quo_signed;
         default:                final_result = rem_signed;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         neg_q    <= 1'b0;
         mag_b_q  <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         mag_b_q  <= mag_b_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = fast ? S_DONE : S_CALC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC:  if (last_iter) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Remainder sign follows the dividend; quotient and product follow sA xor sB.
   always_comb begin
      op_d     = op_q;
      neg_d    = neg_q;
      mag_b_d  = mag_b_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      if (accept) begin
         op_d    = funct3;
         neg_d   = (funct3 == 3'b110) ? sgn_a : (sgn_a ^ sgn_b);
         mag_b_d = mag_b_in;
         acc_d   = {{XLEN{1'b0}}, mag_a_in};
         rem_d   = '0;
         cnt_d   = '0;
         if (fast) result_d = fast_result;
      end else if (state_q == S_CALC) begin
         acc_d = acc_step;
         rem_d = rem_step;
         cnt_d = cnt_q + CW'(1);
         if (last_iter) result_d = final_result;
      end
   end

   always_comb begin
      busy      = (state_q == S_CALC);
      done      = (state_q == S_DONE);
      result    = result_q;
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Self-checking bench for muldiv_seq_unit: directed RV32M cases, fast paths,
// handshake corners and random operations against a native-arithmetic model.
module tb_muldiv_seq_unit;
   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [1:0]  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q[$];

   muldiv_seq_unit #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .funct3    (funct3),
      .rs1       (rs1),
      .rs2       (rs2),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .dbg_state (dbg_state)
   );

   // Clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [63:0] ua, ub, sa, sb, p;
      ua = {32'b0, a};
      ub = {32'b0, b};
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      case (f)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return $signed(a) / $signed(b);
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return $signed(a) % $signed(b);
         end
         default: begin
            if (b == 32'd0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && b == 32'd0) return 1;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Scoreboard monitor: every done pulse pops one expected result.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         check_eq("busy_done_exclusive", {31'b0, busy}, 32'd0);
         check_eq("sb_has_entry", {31'b0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) check_eq("result", result, exp_q.pop_front());
      end
   end

   // Driver: one start pulse, then measure latency and busy cycles.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      int n, busy_n, lat;
      logic seen;
      lat = exp_lat(f, a, b);
      @(negedge clk);
      start  = 1'b1;
      funct3 = f;
      rs1    = a;
      rs2    = b;
      exp_q.push_back(ref_model(f, a, b));
      @(posedge clk);
      #1 start = 1'b0;
      n = 0; busy_n = 0; seen = 1'b0;
      while (!seen && n < 100) begin
         @(negedge clk);
         n++;
         if (busy) busy_n++;
         if (done) seen = 1'b1;
      end
      check_eq("latency", n, lat);
      check_eq("busy_cycles", busy_n, lat - 1);
   endtask

   initial begin
      int n, done_n;
      logic [31:0] first_res;
      logic [2:0]  rf;
      logic [31:0] ra, rb;

      rst = 1'b0; start = 1'b0; funct3 = 3'd0; rs1 = '0; rs2 = '0;
      #12;
      check_eq("reset_busy", {31'b0, busy}, 32'd0);
      check_eq("reset_done", {31'b0, done}, 32'd0);
      check_eq("reset_result", result, 32'd0);
      check_eq("reset_state", {30'b0, dbg_state}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Directed multiply / divide
      run_op(3'd0, 32'd7, 32'hFFFF_FFFA);
      run_op(3'd1, 32'd7, 32'hFFFF_FFFA);
      run_op(3'd3, 32'd7, 32'hFFFF_FFFA);
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
      run_op(3'd5, 32'hFFFF_FFF9, 32'd2);
      run_op(3'd7, 32'hFFFF_FFF9, 32'd2);
      run_op(3'd0, 32'h1234_5678, 32'd0);

      // Fast paths
      run_op(3'd4, 32'd5, 32'd0);
      run_op(3'd7, 32'd5, 32'd0);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

      // Abort by reset mid-calculation
      @(negedge clk);
      start = 1'b1; funct3 = 3'd0; rs1 = 32'd7; rs2 = 32'd6;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check_eq("abort_busy", {31'b0, busy}, 32'd0);
      check_eq("abort_done", {31'b0, done}, 32'd0);
      check_eq("abort_result", result, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      done_n = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) done_n++;
      end
      check_eq("no_done_after_abort", done_n, 32'd0);
      run_op(3'd0, 32'd7, 32'd6);

      // start held high during CALC with other operands is ignored
      @(negedge clk);
      start = 1'b1; funct3 = 3'd0; rs1 = 32'd1000; rs2 = 32'd3;
      exp_q.push_back(ref_model(3'd0, 32'd1000, 32'd3));
      @(posedge clk);
      #1 funct3 = 3'd5; rs1 = 32'd99; rs2 = 32'd0;
      n = 0;
      repeat (20) begin
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("held_start_latency", n, 32'd33);

      // Back-to-back: new start accepted in the DONE cycle
      @(negedge clk);
      start = 1'b1; funct3 = 3'd1; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1357_9BDF;
      first_res = ref_model(3'd1, 32'hDEAD_BEEF, 32'h1357_9BDF);
      exp_q.push_back(first_res);
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (done) break;
      end
      check_eq("b2b_first_latency", n, 32'd33);
      start = 1'b1; funct3 = 3'd4; rs1 = 32'hF000_0001; rs2 = 32'd77;
      exp_q.push_back(ref_model(3'd4, 32'hF000_0001, 32'd77));
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (n == 16) check_eq("b2b_result_held", result, first_res);
         if (done) break;
      end
      check_eq("b2b_second_latency", n, 32'd33);

      // Random operations
      for (int i = 0; i < 16; i++) begin
         rf = 3'($urandom_range(0, 7));
         ra = (i % 5 == 0) ? 32'h8000_0000 : $urandom();
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 9));
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom();
         endcase
         run_op(rf, ra, rb);
      end

      repeat (3) @(negedge clk);
      check_eq("sb_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
